bus_mem: RTL and testbench



---
 rtl/cache_pkg.sv | 23 ++
 rtl/bus_mem_array.sv | 38 +++
 rtl/bus_mem.sv | 129 ++++++++++++
 tb/tb_bus_mem.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache/bus definitions: memory FSM states and width helpers
// reused by the bus and its backing memory.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } bus_mem_state_e;

    function automatic int beats_f(input int block_width, input int dma_width);
        return block_width / dma_width;
    endfunction

    function automatic int beat_cnt_width_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int lat_cnt_width_f(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Beat-wide storage with one synchronous write port and one registered
// read port; read data appears the cycle after the address.
module bus_mem_array #(
    parameter  int width_p   = 64,
    parameter  int els_p     = 512,
    localparam int addr_w_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 w_v_i,
    input  logic [addr_w_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic                 r_v_i,
    input  logic [addr_w_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem [els_p];
    logic [width_p-1:0] r_data_reg;

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data_reg <= '0;
        end else if (r_v_i) begin
            r_data_reg <= mem[r_addr_i];
        end
    end

    assign r_data_o = r_data_reg;

endmodule

// File: rtl/bus_mem.sv
// Banked backing memory on the cache bus: single-beat writes, block reads
// answered after a fixed latency as a burst of consecutive beats.
module bus_mem
    import cache_pkg::*;
#(
    parameter int block_width_p    = 8,
    parameter int dma_data_width_p = 2,
    parameter int mem_words_p      = 4096,
    parameter int latency_p        = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          mem_valid_i,
    output logic                          mem_ready_o,
    input  logic                          mem_we_i,
    input  logic [31:0]                   mem_addr_i,
    input  logic [dma_data_width_p*32-1:0] mem_wdata_i,
    output logic                          mem_valid_o,
    output logic [dma_data_width_p*32-1:0] mem_data_o
);

    localparam int beats_lp    = beats_f(block_width_p, dma_data_width_p);
    localparam int beat_w_lp   = beat_cnt_width_f(beats_lp);
    localparam int lat_w_lp    = lat_cnt_width_f(latency_p);
    localparam int entries_lp  = mem_words_p / dma_data_width_p;
    localparam int entry_w_lp  = $clog2(entries_lp);
    localparam int beat_off_lp = $clog2(dma_data_width_p);
    localparam logic [entry_w_lp-1:0] block_mask_lp = ~entry_w_lp'(beats_lp - 1);

    bus_mem_state_e        state_reg, state_next;
    logic [lat_w_lp-1:0]   lat_cnt_reg, lat_cnt_next;
    logic [beat_w_lp-1:0]  beat_reg, beat_next;
    logic [entry_w_lp-1:0] base_reg, base_next;
    logic                  ready_reg, ready_next;
    logic                  valid_reg, valid_next;

    logic                  accept, rd_accept, wr_en, rd_en;
    logic [29:0]           word_idx;
    logic [entry_w_lp-1:0] req_entry, req_block, rd_addr;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^mem_addr_i[1:0];
    assign word_idx  = mem_addr_i[31:2] % 30'(mem_words_p);
    assign req_entry = entry_w_lp'(word_idx >> beat_off_lp);
    assign req_block = req_entry & block_mask_lp;

    assign accept    = mem_valid_i & ready_reg;
    assign rd_accept = accept & ~mem_we_i;
    // A write sampled while reset is still high must not land in the array.
    assign wr_en     = accept & mem_we_i & ~reset_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= '0;
            beat_reg    <= '0;
            base_reg    <= '0;
            ready_reg   <= 1'b1;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            beat_reg    <= beat_next;
            base_reg    <= base_next;
            ready_reg   <= ready_next;
            valid_reg   <= valid_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        beat_next    = beat_reg;
        base_next    = base_reg;
        unique case (state_reg)
            IDLE: begin
                if (rd_accept) begin
                    base_next    = req_block;
                    beat_next    = '0;
                    lat_cnt_next = lat_w_lp'(latency_p - 1);
                    state_next   = (latency_p == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                // Leave as the count reaches zero so beat 0 lands latency_p cycles after accept.
                lat_cnt_next = lat_cnt_reg - lat_w_lp'(1);
                if (lat_cnt_reg == lat_w_lp'(1)) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (beat_reg == beat_w_lp'(beats_lp - 1)) begin
                    beat_next  = '0;
                    state_next = IDLE;
                end else begin
                    beat_next = beat_reg + beat_w_lp'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from next-state; the array read is issued one
    // cycle ahead so its data lines up with the beat it belongs to.
    always_comb begin
        ready_next = (state_next == IDLE);
        valid_next = (state_next == BURST);
        rd_en      = (state_next == BURST);
        rd_addr    = base_next | entry_w_lp'(beat_next);
    end

    bus_mem_array #(
        .width_p(dma_data_width_p * 32),
        .els_p  (entries_lp)
    ) array (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .w_v_i   (wr_en),
        .w_addr_i(req_entry),
        .w_data_i(mem_wdata_i),
        .r_v_i   (rd_en),
        .r_addr_i(rd_addr),
        .r_data_o(mem_data_o)
    );

    assign mem_ready_o = ready_reg;
    assign mem_valid_o = valid_reg;

endmodule

// File: tb/tb_bus_mem.sv
// Directed bench for bus_mem: a scoreboard queue holds expected read beats
// with their due cycle; a negedge monitor pops and compares them.
module tb_bus_mem;

    localparam int BW    = 8;
    localparam int DW    = 2;
    localparam int MW    = 1024;
    localparam int LAT   = 3;
    localparam int BEATS = BW / DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        a_valid_i, a_we_i, a_ready_o, a_valid_o;
    logic [31:0] a_addr_i;
    logic [63:0] a_wdata_i, a_data_o;
    logic        b_valid_i, b_we_i, b_ready_o, b_valid_o;
    logic [31:0] b_addr_i;
    logic [63:0] b_wdata_i, b_data_o;

    bus_mem #(.block_width_p(BW), .dma_data_width_p(DW), .mem_words_p(MW), .latency_p(LAT)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .mem_valid_i(a_valid_i), .mem_ready_o(a_ready_o),
        .mem_we_i(a_we_i), .mem_addr_i(a_addr_i), .mem_wdata_i(a_wdata_i),
        .mem_valid_o(a_valid_o), .mem_data_o(a_data_o)
    );

    bus_mem #(.block_width_p(BW), .dma_data_width_p(DW), .mem_words_p(MW), .latency_p(1)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .mem_valid_i(b_valid_i), .mem_ready_o(b_ready_o),
        .mem_we_i(b_we_i), .mem_addr_i(b_addr_i), .mem_wdata_i(b_wdata_i),
        .mem_valid_o(b_valid_o), .mem_data_o(b_data_o)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model[int];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int base, input int k);
        logic [31:0] lo, hi;
        lo = model.exists(base + 2 * k)     ? model[base + 2 * k]     : 'x;
        hi = model.exists(base + 2 * k + 1) ? model[base + 2 * k + 1] : 'x;
        return {hi, lo};
    endfunction

    // Scoreboard monitor for the latency-3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (a_valid_o) begin
            chk("beat_outstanding", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("beat_cycle", 64'(cyc), 64'(e.cyc));
                chk("beat_data", a_data_o, e.data);
                $display("beat cycle=%0d data=%h", cyc, a_data_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [63:0] d);
        int w;
        w = int'((addr >> 2) % MW) & ~1;
        model[w]     = d[31:0];
        model[w + 1] = d[63:32];
        a_valid_i = 1'b1; a_we_i = 1'b1; a_addr_i = addr; a_wdata_i = d;
        $display("write addr=%h data=%h", addr, d);
        tick();
        a_valid_i = 1'b0;
    endtask

    // Read a block; optionally keep mem_valid_i high with another request while busy.
    task automatic rd(input logic [31:0] addr, input bit hold, input logic hold_we,
                      input logic [31:0] hold_addr, input logic [63:0] hold_data);
        int base, n;
        base = int'((addr >> 2) % MW) & ~(BW - 1);
        n = cyc;
        for (int k = 0; k < BEATS; k++) q.push_back('{exp_beat(base, k), n + LAT + k});
        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = addr;
        $display("read addr=%h hold=%0d", addr, hold);
        tick();
        if (hold) begin
            a_we_i = hold_we; a_addr_i = hold_addr; a_wdata_i = hold_data;
        end else begin
            a_valid_i = 1'b0;
        end
        for (int c = 1; c <= LAT + BEATS; c++) begin
            if (c == LAT + BEATS) a_valid_i = 1'b0;
            @(negedge clk);
            chk($sformatf("ready_t+%0d", c), 64'(a_ready_o), 64'(c == LAT + BEATS));
            tick();
        end
        chk("burst_drained", 64'(q.size()), 64'(0));
        chk("data_hold", a_data_o, exp_beat(base, BEATS - 1));
    endtask

    initial begin
        int n;
        reset_i = 1'b1;
        a_valid_i = 1'b0; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0;
        b_valid_i = 1'b0; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_ready", 64'(a_ready_o), 64'(1));
        chk("rst_valid", 64'(a_valid_o), 64'(0));
        chk("rst_data", a_data_o, 64'(0));
        chk("rst_ready_b", 64'(b_ready_o), 64'(1));
        tick();

        // latency_p = 1 instance: fill block at 0x40, read it back.
        for (int k = 0; k < BEATS; k++) begin
            b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = 32'h40 + 32'(8 * k);
            b_wdata_i = {32'(200 + 2 * k + 1), 32'(200 + 2 * k)};
            tick();
        end
        b_we_i = 1'b0; b_addr_i = 32'h4C;
        tick();
        b_valid_i = 1'b0;
        for (int c = 1; c <= BEATS + 1; c++) begin
            @(negedge clk);
            chk($sformatf("lat1_ready_t+%0d", c), 64'(b_ready_o), 64'(c == BEATS + 1));
            chk($sformatf("lat1_valid_t+%0d", c), 64'(b_valid_o), 64'(c <= BEATS));
            if (c <= BEATS)
                chk($sformatf("lat1_data_t+%0d", c), b_data_o,
                    {32'(200 + 2 * (c - 1) + 1), 32'(200 + 2 * (c - 1))});
            $display("lat1 cycle t+%0d valid=%0d ready=%0d data=%h", c, b_valid_o, b_ready_o, b_data_o);
            tick();
        end

        // Back-to-back writes, then a read of the same block the very next cycle.
        for (int k = 0; k < BEATS; k++) wr(32'h100 + 32'(8 * k), {32'(2 * k + 1), 32'(2 * k)});
        rd(32'h104, 1'b0, 1'b0, '0, '0);

        // Requests held during a busy burst are ignored.
        rd(32'h100, 1'b1, 1'b0, 32'h200, '0);
        rd(32'h100, 1'b1, 1'b1, 32'h100, 64'hDEAD_BEEF_DEAD_BEEF);
        rd(32'h100, 1'b0, 1'b0, '0, '0);

        // Index wraps modulo the capacity.
        wr(32'h08, 64'h0000_0033_0000_0022);
        wr(32'h10, 64'h0000_0055_0000_0044);
        wr(32'h18, 64'h0000_0077_0000_0066);
        wr(32'h1000, 64'hA5A5_0001_5A5A_0000);
        rd(32'h0, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of a burst, with a write sampled while reset is high.
        n = cyc;
        q.push_back('{exp_beat(256 / 4, 0), n + LAT});
        q.push_back('{exp_beat(256 / 4, 1), n + LAT + 1});
        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 32'h100;
        $display("read addr=%h (reset at beat 2)", a_addr_i);
        tick();
        a_valid_i = 1'b0;
        repeat (LAT + 1) tick();
        #1;
        chk("beat2_valid", 64'(a_valid_o), 64'(1));
        reset_i = 1'b1;
        #1;
        chk("midrst_valid", 64'(a_valid_o), 64'(0));
        chk("midrst_ready", 64'(a_ready_o), 64'(1));
        a_valid_i = 1'b1; a_we_i = 1'b1; a_addr_i = 32'h100; a_wdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        a_valid_i = 1'b0;
        chk("midrst_data", a_data_o, 64'(0));
        repeat (6) tick();
        chk("midrst_no_beats", 64'(q.size()), 64'(0));
        rd(32'h100, 1'b0, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
